cory_dupm: RTL and testbench
============================

# cory_dupm

Parametrised M-way broadcast/multicast splitter for valid/ready (v/r) streams. It generalises the two-way duplicator in three ways: M outputs, a per-beat destination mask, and a per-output queue depth. Each input beat goes to every output selected by its mask. The beat is accepted once all selected outputs have taken it, with outputs allowed to take it in different cycles. It sits wherever one producer feeds several independent consumers, such as a fan-out of command or descriptor streams.

## Interface
- N, 8: data width in bits.
- M, 4: number of outputs, 2..16.
- Q, 0: per-output queue depth, passed to each cory_queue. 0 means combinational pass-through.
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_a_v  in  1  input valid.
- i_a_d  in  N  input data.
- i_a_m  in  M  destination mask. Bit k selects output k.
- o_a_r  out  1  input ready. The beat is accepted in the cycle i_a_v && o_a_r.
- o_z_v  out  M  per-output valid.
- o_z_d  out  M*N  per-output data. Output k occupies bits [k*N +: N].
- i_z_r  in  M  per-output ready.
- o_cnt  out  M*16  per-output delivered-beat counters. Present only under CORY_DUPM_CNT_EN.

## Operation
- Internal register done_d[M-1:0] records the outputs that have already taken the current beat.
- Internal valid per output: int_v[k] = i_a_v && i_a_m[k] && !done_d[k].
- done[k] = (int_v[k] && int_r[k]) || done_d[k] || !i_a_m[k], where int_r is the ready of queue k.
- o_a_r = &done. It is combinational and meaningful only while i_a_v is high.
- On each clk:
  - if i_a_v && &done, done_d <= 0;
  - otherwise done_d <= done_d | (int_v & int_r).
- Mask 0 with i_a_v high: o_a_r = 1 in the same cycle. The beat is dropped and nothing is emitted.
- Each selected output receives the beat exactly once, however its ready toggles.
- Producer rule: i_a_d and i_a_m stay stable while i_a_v is high and not yet accepted. Violating this is undefined behaviour, checked by an assertion in simulation.
- Outputs never block one another beyond the beat currently in flight. A slow output holds o_a_r low; faster outputs hold nothing extra.
- Output order per channel equals input order. There is no ordering guarantee across channels.

## Timing
- Reset values: done_d = 0, o_z_v = 0, all queues empty, o_cnt = 0.
- o_a_r after reset: 0 whenever i_a_v is high with a nonzero mask and any selected int_r is low.
- Q = 0:
  - o_z_v[k] = int_v[k] combinationally, and i_z_r[k] = int_r[k].
  - Zero latency; a fully ready beat is accepted in one cycle.
- Q >= 1:
  - Input-to-o_z_v latency is 1 cycle.
  - Full throughput of 1 beat per cycle while no selected queue is full.
- Split acceptance: if output 0 is ready in cycle t and output 1 in cycle t+2, then:
  - output 0 is done at t;
  - done_d[0] = 1 during t+1..t+2;
  - o_a_r = 1 at t+2;
  - done_d clears at t+3.
- Simultaneous completion and acceptance in the same cycle: the clear takes priority, and the next beat starts with done_d = 0.
- Asynchronous reset mid-beat: done_d and queue contents are lost. The producer re-presents the beat after reset.

## Configuration
- CORY_DUPM_CNT_EN defined:
  - adds o_cnt;
  - counter k increments on o_z_v[k] && i_z_r[k];
  - 16 bits per counter, wrapping from 0xFFFF to 0;
  - reset to 0.
- CORY_DUPM_CNT_EN undefined: the counters and the o_cnt port are absent. Data-path behaviour is identical.

## Structure
- Shared package cory_pkg holds:
  - the clog2 function;
  - the localparam CORY_CNT_W = 16.
- Sub-module: cory_queue, instantiated M times in a generate loop, one per output, each with depth Q.
- Under CORY_MON, one cory_monitor per output.

## Test plan
- M=4, Q=0, mask 4'b1111, all ready, data 0x11..0x14 on consecutive cycles -> each output sees 0x11..0x14 in order; o_a_r high every cycle.
- Mask 4'b0101, data 0xA5 -> only outputs 0 and 2 emit 0xA5; outputs 1 and 3 stay silent; the beat is accepted in 1 cycle.
- Mask 4'b0000, data 0x3C -> o_a_r = 1 the same cycle, and no output valid.
- Mask 4'b0011, i_z_r[0] high at t, i_z_r[1] high only at t+2 -> output 0 emits exactly one beat; o_a_r rises at t+2; there is no duplicate on output 0.
- Q=2, random ready per output, 1000 random beats and masks -> the scoreboard matches per-output order and count; with CORY_DUPM_CNT_EN, o_cnt[k] equals the number of beats delivered to output k.
- reset_n asserted with done_d = 4'b0010 mid-beat -> all o_z_v = 0 and done_d = 0 immediately; normal operation after release.

Source files
------------

// File: rtl/cory_pkg.sv
// Shared package for the cory stream blocks: ceiling-log2 helper and the
// delivered-beat counter width.
package cory_pkg;

  localparam int CORY_CNT_W = 16;

  // Smallest r with (1 << r) >= v; clog2(0) = clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cory_dupm_if.sv
// Bundle of the cory_dupm stream ports: one input v/r stream with a
// destination mask, and M output v/r streams with flattened data.
interface cory_dupm_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic           i_a_v;
  logic [N-1:0]   i_a_d;
  logic [M-1:0]   i_a_m;
  logic           o_a_r;
  logic [M-1:0]   o_z_v;
  logic [M*N-1:0] o_z_d;
  logic [M-1:0]   i_z_r;

  // The splitter itself.
  modport slave (
    input  i_a_v, i_a_d, i_a_m, i_z_r,
    output o_a_r, o_z_v, o_z_d
  );

  // Producer plus all consumers, seen from the outside.
  modport master (
    output i_a_v, i_a_d, i_a_m, i_z_r,
    input  o_a_r, o_z_v, o_z_d
  );
endinterface

// File: rtl/cory_monitor.sv
// Simulation-only v/r protocol monitor, built only when CORY_MON is
// defined: once valid is raised it must hold, with stable data, until the
// consumer takes the beat.
`ifdef CORY_MON
module cory_monitor #(
  parameter int N = 8
) (
  input logic         clk,
  input logic         reset_n,
  input logic         v,
  input logic         r,
  input logic [N-1:0] d
);

  // A stalled beat must be presented unchanged on the following cycle.
  property p_hold;
    @(posedge clk) disable iff (!reset_n)
      (v && !r) |=> (v && $stable(d));
  endproperty

  a_hold: assert property (p_hold);

endmodule
`endif

// File: rtl/cory_queue.sv
// Per-output v/r queue. Q = 0 is a wire-through; Q >= 1 is a circular FIFO
// of depth Q whose output is registered (one cycle of latency) and whose
// input ready is simply "not full".
module cory_queue
  import cory_pkg::*;
#(
  parameter int N = 8,
  parameter int Q = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         wr_v,
  input  logic [N-1:0] wr_d,
  output logic         wr_r,
  output logic         rd_v,
  output logic [N-1:0] rd_d,
  input  logic         rd_r
);

  if (Q == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset_n;
    assign rd_v = wr_v;
    assign rd_d = wr_d;
    assign wr_r = rd_r;
  end else begin : g_fifo
    localparam int AW = (Q > 1) ? clog2(Q) : 1;
    localparam int CW = clog2(Q + 1);

    logic [N-1:0]  mem [Q];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign wr_r = (cnt != CW'(Q));
    assign rd_v = (cnt != '0);
    assign rd_d = mem[rp];
    assign push = wr_v && wr_r;
    assign pop  = rd_v && rd_r;

    // Storage is never reset; only the pointers and fill count are.
    always_ff @(posedge clk) begin
      if (push) mem[wp] <= wr_d;
    end

    // Pointer and occupancy bookkeeping; pointers wrap at Q, which need
    // not be a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= (wp == AW'(Q - 1)) ? '0 : wp + AW'(1);
        if (pop)  rp <= (rp == AW'(Q - 1)) ? '0 : rp + AW'(1);
        if (push && !pop)      cnt <= cnt + CW'(1);
        else if (pop && !push) cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/cory_dupm.sv
// cory_dupm: M-way broadcast/multicast splitter for v/r streams.
// Each input beat is offered to every output selected by its mask; outputs
// may take it in different cycles and done_d remembers which already have.
// The input is accepted once every selected output is done. Each output has
// its own cory_queue of depth Q (Q = 0 is combinational pass-through).
// Build options:
//   CORY_DUPM_CNT_EN - adds o_cnt, one 16-bit wrapping delivered-beat
//                      counter per output.
//   CORY_MON         - adds a cory_monitor on every output stream.
module cory_dupm
  import cory_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int Q = 0
) (
  input logic        clk,
  input logic        reset_n,
  cory_dupm_if.slave bus
`ifdef CORY_DUPM_CNT_EN
  ,
  output logic [M*CORY_CNT_W-1:0] o_cnt
`endif
);

  logic [M-1:0]   done_d;
  logic [M-1:0]   int_v;
  logic [M-1:0]   int_r;
  logic [M-1:0]   take;
  logic [M-1:0]   done;
  logic [M-1:0]   z_v;
  logic [M*N-1:0] z_d;

  // Offer the beat only to selected outputs that have not taken it yet.
  // Gating with reset_n keeps the pass-through outputs silent in reset.
  assign int_v = {M{bus.i_a_v && reset_n}} & bus.i_a_m & ~done_d;
  assign take  = int_v & int_r;
  assign done  = take | done_d | ~bus.i_a_m;

  assign bus.o_a_r = &done;
  assign bus.o_z_v = z_v;
  assign bus.o_z_d = z_d;

  // Track partial delivery; acceptance wins over accumulation so the next
  // beat always starts with a clean done_d.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_d <= '0;
    end else if (bus.i_a_v && bus.o_a_r) begin
      done_d <= '0;
    end else begin
      done_d <= done_d | take;
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_out
    cory_queue #(
      .N (N),
      .Q (Q)
    ) u_queue (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_v    (int_v[k]),
      .wr_d    (bus.i_a_d),
      .wr_r    (int_r[k]),
      .rd_v    (z_v[k]),
      .rd_d    (z_d[k*N +: N]),
      .rd_r    (bus.i_z_r[k])
    );

`ifdef CORY_MON
    cory_monitor #(
      .N (N)
    ) u_mon (
      .clk     (clk),
      .reset_n (reset_n),
      .v       (z_v[k]),
      .r       (bus.i_z_r[k]),
      .d       (z_d[k*N +: N])
    );
`endif
  end

`ifdef CORY_DUPM_CNT_EN
  logic [CORY_CNT_W-1:0] cnt [M];

  // One wrapping counter per output, stepped on every delivered beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < M; k++) cnt[k] <= '0;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (z_v[k] && bus.i_z_r[k]) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  // Flatten the counters onto the output port, output k at [k*16 +: 16].
  always_comb begin
    o_cnt = '0;
    for (int k = 0; k < M; k++) o_cnt[k*CORY_CNT_W +: CORY_CNT_W] = cnt[k];
  end
`endif

  // While a beat is pending its data and mask must not change.
  property p_producer_stable;
    @(posedge clk) disable iff (!reset_n)
      (bus.i_a_v && !bus.o_a_r) |=>
        (!bus.i_a_v || ($stable(bus.i_a_d) && $stable(bus.i_a_m)));
  endproperty

  a_producer_stable: assert property (p_producer_stable);

endmodule

// File: tb/tb_cory_dupm.sv
// Bench for cory_dupm: a Q=0 instance for the directed cases and a Q=2
// instance for random traffic, both scored against per-output queues of
// expected beats.
module tb_cory_dupm;
  localparam int N = 8;
  localparam int M = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cory_dupm_if #(.N(N), .M(M)) if0 ();
  cory_dupm_if #(.N(N), .M(M)) if2 ();

`ifdef CORY_DUPM_CNT_EN
  logic [M*16-1:0] cnt0;
  logic [M*16-1:0] cnt2;
`endif

  cory_dupm #(.N(N), .M(M), .Q(0)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if0.slave)
`ifdef CORY_DUPM_CNT_EN
    ,
    .o_cnt   (cnt0)
`endif
  );

  cory_dupm #(.N(N), .M(M), .Q(2)) u_dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if2.slave)
`ifdef CORY_DUPM_CNT_EN
    ,
    .o_cnt   (cnt2)
`endif
  );

  logic [N-1:0] sb0 [M][$];
  logic [N-1:0] sb2 [M][$];
  int dcnt0 [M];
  int dcnt2 [M];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic present0(input logic [N-1:0] d, input logic [M-1:0] m);
    if0.i_a_v = 1'b1;
    if0.i_a_d = d;
    if0.i_a_m = m;
    for (int k = 0; k < M; k++) if (m[k]) sb0[k].push_back(d);
  endtask

  task automatic present2(input logic [N-1:0] d, input logic [M-1:0] m);
    if2.i_a_v = 1'b1;
    if2.i_a_d = d;
    if2.i_a_m = m;
    for (int k = 0; k < M; k++) if (m[k]) sb2[k].push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [M-1:0] rnd_rdy();
    logic [M-1:0] r;
    for (int k = 0; k < M; k++) r[k] = ($urandom_range(0, 3) != 0);
    return r;
  endfunction

  // Score every output handshake of the Q=0 instance.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < M; k++) begin
        if (if0.o_z_v[k] && if0.i_z_r[k]) begin
          if (sb0[k].size() == 0) begin
            check($sformatf("q0_out%0d_extra", k), 32'd1, 32'd0);
          end else begin
            check($sformatf("q0_out%0d_data", k), 32'(if0.o_z_d[k*N +: N]), 32'(sb0[k].pop_front()));
            dcnt0[k]++;
          end
        end
      end
    end
  end

  // Score every output handshake of the Q=2 instance.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int k = 0; k < M; k++) begin
        if (if2.o_z_v[k] && if2.i_z_r[k]) begin
          if (sb2[k].size() == 0) begin
            check($sformatf("q2_out%0d_extra", k), 32'd1, 32'd0);
          end else begin
            check($sformatf("q2_out%0d_data", k), 32'(if2.o_z_d[k*N +: N]), 32'(sb2[k].pop_front()));
            dcnt2[k]++;
          end
        end
      end
    end
  end

  initial begin
    logic acc;
    if0.i_a_v = 1'b0; if0.i_a_d = '0; if0.i_a_m = '0; if0.i_z_r = '0;
    if2.i_a_v = 1'b0; if2.i_a_d = '0; if2.i_a_m = '0; if2.i_z_r = '0;
    for (int k = 0; k < M; k++) begin dcnt0[k] = 0; dcnt2[k] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_zv0", 32'(if0.o_z_v), 32'h0);
    check("rst_zv2", 32'(if2.o_z_v), 32'h0);
    check("rst_done_d", 32'(u_dut0.done_d), 32'h0);
`ifdef CORY_DUPM_CNT_EN
    check("rst_cnt0", 32'(cnt0[31:0]), 32'h0);
    check("rst_cnt2", 32'(cnt2[31:0]), 32'h0);
`endif
    step();
    reset_n = 1'b1;

    // Broadcast 0x11..0x14; first beat stalls one cycle on no ready
    step();
    present0(8'h11, 4'hF);
    if0.i_z_r = 4'h0;
    @(negedge clk);
    check("stall_ar", 32'(if0.o_a_r), 32'h0);
    check("stall_zv", 32'(if0.o_z_v), 32'hF);
    step();
    if0.i_z_r = 4'hF;
    @(negedge clk);
    check("bc_ar_11", 32'(if0.o_a_r), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      step();
      present0(8'(8'h10 + i), 4'hF);
      @(negedge clk);
      check($sformatf("bc_ar_1%0d", i), 32'(if0.o_a_r), 32'h1);
    end

    // Multicast to outputs 0 and 2
    step();
    present0(8'hA5, 4'b0101);
    @(negedge clk);
    check("mc_ar", 32'(if0.o_a_r), 32'h1);
    check("mc_zv", 32'(if0.o_z_v), 32'h5);

    // Empty mask: dropped, accepted at once
    step();
    present0(8'h3C, 4'b0000);
    @(negedge clk);
    check("m0_ar", 32'(if0.o_a_r), 32'h1);
    check("m0_zv", 32'(if0.o_z_v), 32'h0);

    // Split acceptance: output 0 ready at t, output 1 at t+2
    step();
    present0(8'h5B, 4'b0011);
    if0.i_z_r = 4'b0001;
    @(negedge clk);
    check("split_t_ar", 32'(if0.o_a_r), 32'h0);
    check("split_t_zv", 32'(if0.o_z_v), 32'h3);
    step();
    if0.i_z_r = 4'b0000;
    @(negedge clk);
    check("split_t1_ar", 32'(if0.o_a_r), 32'h0);
    check("split_t1_zv", 32'(if0.o_z_v), 32'h2);
    check("split_t1_dd", 32'(u_dut0.done_d), 32'h1);
    step();
    if0.i_z_r = 4'b0010;
    @(negedge clk);
    check("split_t2_ar", 32'(if0.o_a_r), 32'h1);
    check("split_t2_dd", 32'(u_dut0.done_d), 32'h1);
    step();
    if0.i_a_v = 1'b0;
    if0.i_z_r = 4'hF;
    @(negedge clk);
    check("split_t3_dd", 32'(u_dut0.done_d), 32'h0);
    check("split_t3_zv", 32'(if0.o_z_v), 32'h0);

    // Reset in the middle of a beat with done_d = 4'b0010
    step();
    present0(8'hC3, 4'b0011);
    if0.i_z_r = 4'b0010;
    @(negedge clk);
    check("mid_zv", 32'(if0.o_z_v), 32'h3);
    step();
    if0.i_z_r = 4'b0000;
    @(negedge clk);
    check("mid_dd", 32'(u_dut0.done_d), 32'h2);
    #2;
    reset_n = 1'b0;
    for (int k = 0; k < M; k++) begin
      sb0[k].delete();
      sb2[k].delete();
      dcnt0[k] = 0;
      dcnt2[k] = 0;
    end
    #1;
    check("arst_zv", 32'(if0.o_z_v), 32'h0);
    check("arst_dd", 32'(u_dut0.done_d), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    present0(8'hC3, 4'b0011);
    if0.i_z_r = 4'hF;
    @(negedge clk);
    check("post_ar", 32'(if0.o_a_r), 32'h1);
    check("post_zv", 32'(if0.o_z_v), 32'h3);
    step();
    if0.i_a_v = 1'b0;

    // Q=2: one cycle from acceptance to output valid
    present2(8'hE7, 4'hF);
    if2.i_z_r = 4'hF;
    @(negedge clk);
    check("q2_lat_ar", 32'(if2.o_a_r), 32'h1);
    check("q2_lat_zv0", 32'(if2.o_z_v), 32'h0);
    step();
    if2.i_a_v = 1'b0;
    @(negedge clk);
    check("q2_lat_zv1", 32'(if2.o_z_v), 32'hF);

    // Q=2: random beats, masks and per-output ready
    for (int b = 0; b < 1000; b++) begin
      step();
      present2(8'($urandom), 4'($urandom));
      if2.i_z_r = rnd_rdy();
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        if (if2.o_a_r) acc = 1'b1;
        else begin
          step();
          if2.i_z_r = rnd_rdy();
        end
      end
      if (!acc) check($sformatf("accept_timeout_%0d", b), 32'd0, 32'd1);
    end
    step();
    if2.i_a_v = 1'b0;
    if2.i_z_r = 4'hF;
    repeat (8) @(posedge clk);
    #1;

    for (int k = 0; k < M; k++) begin
      check($sformatf("q0_left%0d", k), 32'(sb0[k].size()), 32'd0);
      check($sformatf("q2_left%0d", k), 32'(sb2[k].size()), 32'd0);
`ifdef CORY_DUPM_CNT_EN
      check($sformatf("q0_cnt%0d", k), 32'(cnt0[k*16 +: 16]), 32'(dcnt0[k][15:0]));
      check($sformatf("q2_cnt%0d", k), 32'(cnt2[k*16 +: 16]), 32'(dcnt2[k][15:0]));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
